slc_cfg_loader: RTL
===================

# slc_cfg_loader

Serial configuration writer for the AP3 super logic cell. Receives a framed, CRC-protected bitstream one bit per clock, assembles it in a shadow register and, only on a CRC match, commits LUT contents and per-cell mode/mux selects for all eight logic cells in one cycle. Sits between the fabric configuration controller and the super logic cell's configuration inputs. While a frame is loading it raises a hold output so the cells' flip-flop enables can be gated off.

## Interface
Parameters:
- N_LC, 8, logic cells per super logic cell.
- LUT_BITS, 16, LUT init bits per cell.
- CRC_POLY, 8'h07, CRC-8 polynomial, x^8+x^2+x+1.

Ports:
- QCK  in  1  clock; all state changes on the rising edge.
- QRTN  in  1  reset, synchronous, active-low.
- CFG_START  in  1  one-cycle frame-start strobe.
- CFG_DV  in  1  CFG_DI is valid this cycle.
- CFG_DI  in  1  serial data bit.
- LC_LUT  out  N_LC*LUT_BITS  committed LUT init; cell i at [LUT_BITS*i +: LUT_BITS].
- LC_MODE  out  N_LC  committed mode bit per cell.
- LC_QDI_MUX  out  N_LC  committed QDI mux select per cell.
- LC_BQZ_MUX  out  N_LC  committed BQZ mux select per cell.
- LC_CQZ_MUX  out  N_LC  committed CQZ mux select per cell.
- CFG_BUSY  out  1  frame in progress.
- LC_HOLD  out  1  equals CFG_BUSY; the cells' QEN is gated with it.
- CFG_DONE  out  1  one-cycle pulse on a successful commit.
- CFG_ERR  out  1  sticky CRC-mismatch flag.

## Operation
- Frame: 160 payload bits, then 8 CRC bits. Payload bit k is the k-th accepted bit and lands in shadow[k].
- Cell i occupies shadow[20i +: 20]:
  - [15:0] LUT init.
  - [16] MODE.
  - [17] QDI_MUX.
  - [18] BQZ_MUX.
  - [19] CQZ_MUX.
- CRC bits arrive MSB first.
- CRC runs over the payload bits in arrival order, initial value 8'h00, per bit:
  - fb = crc[7] ^ d.
  - crc = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 0).
- A bit is accepted only when CFG_DV=1 in SHIFT. Bit counter is 8 bits, 0..167.
- FSM states:
  - IDLE: CFG_START -> SHIFT. Clears counter, CRC, received-CRC register and CFG_ERR.
  - SHIFT: each accepted bit increments the counter. Bits 0..159 go to shadow and CRC; bits 160..167 go to the received-CRC register. Acceptance of bit 167 -> CHECK.
  - CHECK, one cycle:
    - Match: copy shadow to all LC_* outputs, pulse CFG_DONE -> IDLE.
    - Mismatch: set CFG_ERR, outputs unchanged -> IDLE.
- CFG_START in SHIFT or CHECK aborts the current frame and restarts SHIFT with cleared counter and CRC. In CHECK the abort takes priority over the commit, so no commit happens.
- CFG_DV and CFG_DI are ignored outside SHIFT.
- Committed outputs change only in CHECK on a match. They are never partially updated.

## Timing
- Reset (QRTN=0 at an edge):
  - state IDLE.
  - LC_LUT, LC_MODE, LC_QDI_MUX, LC_BQZ_MUX, LC_CQZ_MUX all 0.
  - CFG_BUSY, LC_HOLD, CFG_DONE, CFG_ERR all 0.
  - Shadow contents don't-care.
- Reset mid-frame discards the frame. Committed outputs go to 0.
- CFG_START sampled at edge t -> CFG_BUSY=1 from t+1.
- Bit 167 accepted at edge t -> CHECK during cycle t+1.
  - On a match, the commit and CFG_DONE=1 are both visible after edge t+2, and CFG_DONE lasts one cycle.
  - CFG_BUSY drops after edge t+2.
- CFG_ERR sets after edge t+2 and holds until the next CFG_START or reset.
- Minimum frame time with no stalls: 1 + 168 + 1 cycles.
- CFG_DV low stalls with no state change. A stall has no timeout.

## Test plan
- Reset, then an all-zero payload with CRC 8'h00, CFG_DV held high -> CFG_DONE pulses exactly 170 cycles after the START edge. All LC_* outputs are 0 and CFG_ERR=0.
- Payload with cell 3 LUT=16'hA5C3, MODE=1, CQZ_MUX=1, others 0, CRC from the bench model -> LC_LUT[63:48]=16'hA5C3, LC_MODE=8'h08, LC_CQZ_MUX=8'h08, all other outputs 0.
- Same frame with the last CRC bit flipped -> CFG_ERR=1, CFG_DONE stays 0, and the outputs keep their prior values. The next good frame clears CFG_ERR and commits.
- Valid frame with CFG_DV toggled 1,0,0,1 throughout -> same result as without stalls, completing 2x longer. CFG_BUSY and LC_HOLD stay high for the whole frame.
- CFG_START reasserted after 90 bits, then a full valid frame -> only the second frame commits. Reasserted in the CHECK cycle -> no commit and a new SHIFT begins.
- QRTN low for one edge at bit 100 after a prior good commit -> all outputs 0 and state IDLE. Bits without CFG_START are ignored.

Source files
------------

// File: rtl/slc_cfg_loader.sv
// Serial configuration loader for the AP3 super logic cell. It shifts a framed,
// CRC-8 protected bitstream into a shadow register and commits it atomically.
module slc_cfg_loader #(
  parameter int         N_LC     = 8,
  parameter int         LUT_BITS = 16,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic                     QCK,
  input  logic                     QRTN,
  input  logic                     CFG_START,
  input  logic                     CFG_DV,
  input  logic                     CFG_DI,
  output logic [N_LC*LUT_BITS-1:0] LC_LUT,
  output logic [N_LC-1:0]          LC_MODE,
  output logic [N_LC-1:0]          LC_QDI_MUX,
  output logic [N_LC-1:0]          LC_BQZ_MUX,
  output logic [N_LC-1:0]          LC_CQZ_MUX,
  output logic                     CFG_BUSY,
  output logic                     LC_HOLD,
  output logic                     CFG_DONE,
  output logic                     CFG_ERR
);
  localparam int         CELL_W    = LUT_BITS + 4;
  localparam int         PAY_BITS  = N_LC * CELL_W;
  localparam logic [7:0] PAY_LEN   = 8'(PAY_BITS);
  localparam logic [7:0] FRAME_LEN = 8'(PAY_BITS + 8);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, crc, rx_crc;
  logic [PAY_BITS-1:0]   shadow;
  logic                  clear, accept, commit, mismatch;

  logic [N_LC*LUT_BITS-1:0] sh_lut;
  logic [N_LC-1:0]          sh_mode, sh_qdi, sh_bqz, sh_cqz;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
    return {c[6:0], 1'b0} ^ ((c[7] ^ d) ? CRC_POLY : 8'h00);
  endfunction

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    mismatch  = 1'b0;
    case (state)
      IDLE: begin
        if (CFG_START) begin
          clear     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (CFG_START) begin
          clear     = 1'b1;
          state_nxt = SHIFT;
        end else if (cnt == FRAME_LEN) begin
          state_nxt = CHECK;
        end else if (CFG_DV) begin
          accept = 1'b1;
        end
      end
      CHECK: begin
        // a restart here wins over the commit
        if (CFG_START) begin
          clear     = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
          if (crc == rx_crc) commit = 1'b1;
          else               mismatch = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload bit k is shifted in at the top and ends up in shadow[k].
  always_ff @(posedge QCK) begin
    if (accept && cnt < PAY_LEN) shadow <= {CFG_DI, shadow[PAY_BITS-1:1]};
  end

  generate
    for (genvar i = 0; i < N_LC; i++) begin : g_cell
      assign sh_lut[i*LUT_BITS +: LUT_BITS] = shadow[i*CELL_W +: LUT_BITS];
      assign sh_mode[i] = shadow[i*CELL_W + LUT_BITS];
      assign sh_qdi[i]  = shadow[i*CELL_W + LUT_BITS + 1];
      assign sh_bqz[i]  = shadow[i*CELL_W + LUT_BITS + 2];
      assign sh_cqz[i]  = shadow[i*CELL_W + LUT_BITS + 3];
    end
  endgenerate

  always_ff @(posedge QCK) begin
    if (!QRTN) begin
      state      <= IDLE;
      cnt        <= '0;
      crc        <= '0;
      rx_crc     <= '0;
      LC_LUT     <= '0;
      LC_MODE    <= '0;
      LC_QDI_MUX <= '0;
      LC_BQZ_MUX <= '0;
      LC_CQZ_MUX <= '0;
      CFG_DONE   <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      state    <= state_nxt;
      CFG_DONE <= commit;
      if (clear) begin
        cnt     <= '0;
        crc     <= '0;
        rx_crc  <= '0;
        CFG_ERR <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + 8'd1;
        if (cnt < PAY_LEN) crc    <= crc_step(crc, CFG_DI);
        else               rx_crc <= {rx_crc[6:0], CFG_DI};
      end
      if (mismatch) CFG_ERR <= 1'b1;
      if (commit) begin
        LC_LUT     <= sh_lut;
        LC_MODE    <= sh_mode;
        LC_QDI_MUX <= sh_qdi;
        LC_BQZ_MUX <= sh_bqz;
        LC_CQZ_MUX <= sh_cqz;
      end
    end
  end

  assign CFG_BUSY = (state != IDLE);
  assign LC_HOLD  = CFG_BUSY;

endmodule
